// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux16 round-robin arbiter.
//   N_REQ        : number of requesters sharing the mux16 lane
//   SEL_W        : width of the mux16 select / owner index
//   HOLD_MAX_DEF : default hold-timeout limit (0 disables preemption)
//   arb_state_e  : arbiter FSM state encoding
package mux_arb_pkg;

   localparam int N_REQ        = 16;
   localparam int SEL_W        = 4;
   localparam int HOLD_MAX_DEF = 15;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage : mux_arb_pkg

// File: rtl/rr_pick16.sv
// Combinational rotate-priority find-first over 16 request bits.
// Scans upward from ptr, wrapping 15 -> 0, and reports the first set bit.
// Ports:
//   req      [15:0] in  : request vector
//   ptr      [3:0]  in  : index where the scan starts (highest priority)
//   mask_en         in  : when 1, req[mask_idx] is ignored
//   mask_idx [3:0]  in  : index to ignore (the current owner)
//   found           out : 1 when any unmasked request is set
//   idx      [3:0]  out : index of the winning request (0 when none)
module rr_pick16
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             mask_en,
   input  logic [SEL_W-1:0] mask_idx,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [N_REQ-1:0] req_m;
   logic [SEL_W-1:0] cand;

   always_comb begin
      req_m = req;
      if (mask_en) begin
         req_m[mask_idx] = 1'b0;
      end
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      // Walk offsets from farthest to nearest so the nearest set bit
      // (lowest offset from ptr) is the last one written and wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req_m[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule : rr_pick16

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one mux16 bit-lane between 16 requesters.
// The registered owner index drives the mux16 select directly, so the
// select only ever changes on a clock edge. An optional hold timeout
// revokes the grant from an owner that keeps the lane while others wait.
// Ports:
//   clk              in  : clock, rising edge
//   rst_n            in  : synchronous active-low reset
//   req       [15:0] in  : request vector, held high for the whole ownership
//   sel       [3:0]  out : registered owner index (mux16 select)
//   gnt       [15:0] out : registered one-hot grant, zero when idle
//   gnt_valid        out : registered, equals |gnt
//   preempt          out : one-cycle pulse when a grant is revoked by timeout
//   dbg_state        out : current FSM state (IDLE=0, GRANT=1)
module mux16_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic             preempt,
   output logic             dbg_state
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
   localparam bit               HOLD_EN  = (HOLD_MAX != 0);

   arb_state_e       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             preempt_q, preempt_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;

   logic [SEL_W-1:0] pick_ptr;
   logic             pick_mask;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;

   // While granting, the scan starts just past the owner and skips it, so
   // both release and timeout hand the lane to the next requester in order.
   // While idle, the scan starts at ptr with nothing masked.
   always_comb begin
      pick_mask = (state_q == GRANT);
      pick_ptr  = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;
   end

   rr_pick16 u_pick (
      .req      (req),
      .ptr      (pick_ptr),
      .mask_en  (pick_mask),
      .mask_idx (sel_q),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      preempt_d   = 1'b0;
      ptr_d       = ptr_q;
      hold_d      = hold_q;

      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d           = GRANT;
               sel_d             = pick_idx;
               gnt_d             = '0;
               gnt_d[pick_idx]   = 1'b1;
               gnt_valid_d       = 1'b1;
               ptr_d             = pick_idx + SEL_W'(1);
               hold_d            = '0;
            end
         end

         GRANT: begin
            if (!req[sel_q]) begin
               // Release takes priority over a coincident timeout.
               if (pick_found) begin
                  sel_d           = pick_idx;
                  gnt_d           = '0;
                  gnt_d[pick_idx] = 1'b1;
                  ptr_d           = pick_idx + SEL_W'(1);
                  hold_d          = '0;
               end else begin
                  // sel deliberately keeps the last owner.
                  state_d     = IDLE;
                  gnt_d       = '0;
                  gnt_valid_d = 1'b0;
                  hold_d      = '0;
               end
            end else if (HOLD_EN && (hold_q == HOLD_LIM) && pick_found) begin
               sel_d           = pick_idx;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               ptr_d           = pick_idx + SEL_W'(1);
               hold_d          = '0;
               preempt_d       = 1'b1;
            end else if (HOLD_EN && (hold_q != HOLD_LIM)) begin
               // Saturates at the limit; stays there while nobody else waits.
               hold_d = hold_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         preempt_q   <= 1'b0;
         ptr_q       <= '0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         preempt_q   <= preempt_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
      end
   end

   assign sel       = sel_q;
   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign preempt   = preempt_q;
   assign dbg_state = state_q;

endmodule : mux16_rr_arbiter
